// File: rtl/instr_encoder_loader.sv
// Encodes DP/LDR/STR/B instruction fields into ARM words and streams them into imem.
// Optional ENCODER_HALT_PAD_EN appends a branch-to-self halt word after the last instruction.
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [2:0]        req_kind,
    input  logic [3:0]        req_cond,
    input  logic [1:0]        req_alu,
    input  logic              req_s,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rm,
    input  logic [23:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err_illegal
);

`ifdef ENCODER_HALT_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] MAX_ADDR  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       HALT_WORD = 32'hEAFF_FFFE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              last_seen;
    logic              fin;
    logic              pad_pend;

    logic [31:0]       enc_word;
    logic              kind_illegal;
    logic [ADDR_W-1:0] next_addr;
    logic              accept;

    function automatic logic [3:0] alu_cmd(input logic [1:0] alu);
        logic [3:0] cmd;
        case (alu)
            2'b00:   cmd = 4'b0100;
            2'b01:   cmd = 4'b0010;
            2'b10:   cmd = 4'b0000;
            default: cmd = 4'b1100;
        endcase
        return cmd;
    endfunction

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [3:0]  cond,
        input logic [1:0]  alu,
        input logic        s,
        input logic [3:0]  rn,
        input logic [3:0]  rd,
        input logic [3:0]  rm,
        input logic [23:0] imm
    );
        logic [31:0] w;
        case (kind)
            3'd0:    w = {cond, 2'b00, 1'b1, alu_cmd(alu), s, rn, rd, imm[11:0]};
            3'd1:    w = {cond, 2'b00, 1'b0, alu_cmd(alu), s, rn, rd, 8'h00, rm};
            3'd2:    w = {cond, 2'b01, 6'b011001, rn, rd, imm[11:0]};
            3'd3:    w = {cond, 2'b01, 6'b011000, rn, rd, imm[11:0]};
            3'd4:    w = {cond, 4'b1010, imm};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    assign req_ready    = (state == S_LOAD) & ~last_seen & ~full;
    assign accept       = req_valid & req_ready;
    assign busy         = (state == S_LOAD);
    assign done         = (state == S_DONE);
    assign kind_illegal = (req_kind > 3'd4);
    assign enc_word     = encode(req_kind, req_cond, req_alu, req_s, req_rn, req_rd, req_rm, req_imm);
    // A write in flight this cycle has not yet advanced ptr, so the next word goes one past it.
    assign next_addr    = imem_we ? (ptr + ADDR_W'(1)) : ptr;

    // Session FSM, write pipeline and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= BASE;
            last_seen   <= 1'b0;
            fin         <= 1'b0;
            pad_pend    <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= {ADDR_W{1'b0}};
            imem_wd     <= 32'h0000_0000;
            word_count  <= {(ADDR_W+1){1'b0}};
            full        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (imem_we) begin
                word_count <= word_count + (ADDR_W+1)'(1);
                if (ptr != MAX_ADDR) begin
                    ptr <= ptr + ADDR_W'(1);
                end
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        ptr         <= BASE;
                        last_seen   <= 1'b0;
                        fin         <= 1'b0;
                        pad_pend    <= 1'b0;
                        word_count  <= {(ADDR_W+1){1'b0}};
                        full        <= 1'b0;
                        err_illegal <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (fin) begin
                        fin <= 1'b0;
                        // The halt pad only follows a real req_last word that left room behind it.
                        if (PAD_EN && imem_we && (imem_addr != MAX_ADDR)) begin
                            imem_we   <= 1'b1;
                            imem_addr <= imem_addr + ADDR_W'(1);
                            imem_wd   <= HALT_WORD;
                            pad_pend  <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            full  <= imem_we && (imem_addr == MAX_ADDR);
                        end
                    end else if (pad_pend) begin
                        pad_pend <= 1'b0;
                        state    <= S_DONE;
                        full     <= (imem_addr == MAX_ADDR);
                    end else if (accept) begin
                        if (kind_illegal) begin
                            err_illegal <= 1'b1;
                            if (req_last) begin
                                last_seen <= 1'b1;
                                fin       <= 1'b1;
                            end
                        end else begin
                            imem_we   <= 1'b1;
                            imem_addr <= next_addr;
                            imem_wd   <= enc_word;
                            if (req_last || (next_addr == MAX_ADDR)) begin
                                last_seen <= 1'b1;
                                fin       <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encodings, streaming, illegal kinds, address limit, reset abort.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset2 = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_last = 1'b0;
    logic [2:0]  req_kind = 3'd0;
    logic [3:0]  req_cond = 4'd0;
    logic [1:0]  req_alu = 2'd0;
    logic        req_s = 1'b0;
    logic [3:0]  req_rn = 4'd0;
    logic [3:0]  req_rd = 4'd0;
    logic [3:0]  req_rm = 4'd0;
    logic [23:0] req_imm = 24'd0;

    logic        req_ready, imem_we, busy, done, full, err_illegal;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wd;
    logic [6:0]  word_count;

    logic        req_ready2, imem_we2, busy2, done2, full2, err_illegal2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wd2;
    logic [2:0]  word_count2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_kind(req_kind), .req_cond(req_cond), .req_alu(req_alu), .req_s(req_s),
        .req_rn(req_rn), .req_rd(req_rd), .req_rm(req_rm), .req_imm(req_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .word_count(word_count), .busy(busy), .done(done), .full(full),
        .err_illegal(err_illegal)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset2), .start(start2),
        .req_valid(req_valid), .req_ready(req_ready2), .req_last(req_last),
        .req_kind(req_kind), .req_cond(req_cond), .req_alu(req_alu), .req_s(req_s),
        .req_rn(req_rn), .req_rd(req_rd), .req_rm(req_rm), .req_imm(req_imm),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wd(imem_wd2),
        .word_count(word_count2), .busy(busy2), .done(done2), .full(full2),
        .err_illegal(err_illegal2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] kind, input logic [3:0] cond, input logic [1:0] alu,
                         input logic s, input logic [3:0] rn, input logic [3:0] rd,
                         input logic [3:0] rm, input logic [23:0] imm, input logic last);
        req_valid = 1'b1;
        req_kind  = kind;
        req_cond  = cond;
        req_alu   = alu;
        req_s     = s;
        req_rn    = rn;
        req_rd    = rd;
        req_rm    = rm;
        req_imm   = imm;
        req_last  = last;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, imem_we, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_wd"}, imem_wd, 32'd0);
        chk({tag, "_wc"}, word_count, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_done"}, done, 32'd0);
        chk({tag, "_full"}, full, 32'd0);
        chk({tag, "_err"}, err_illegal, 32'd0);
        chk({tag, "_ready"}, req_ready, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("idle_ready", req_ready, 32'd0);

        // Session 1: single DPI word with req_last.
        pulse_start();
        chk("s1_busy", busy, 32'd1);
        chk("s1_ready", req_ready, 32'd1);
        drive(3'd0, 4'hE, 2'b00, 1'b0, 4'd2, 4'd1, 4'd0, 24'h000005, 1'b1);
        tick();
        idle_req();
        chk("dpi_we", imem_we, 32'd1);
        chk("dpi_addr", imem_addr, 32'd0);
        chk("dpi_wd", imem_wd, 32'hE2821005);
        chk("dpi_ready_after_last", req_ready, 32'd0);
        tick();
`ifdef ENCODER_HALT_PAD_EN
        chk("s1_pad_we", imem_we, 32'd1);
        chk("s1_pad_addr", imem_addr, 32'd1);
        chk("s1_pad_wd", imem_wd, 32'hEAFFFFFE);
        tick();
        chk("s1_done", done, 32'd1);
        chk("s1_wc", word_count, 32'd2);
`else
        chk("s1_done", done, 32'd1);
        chk("s1_wc", word_count, 32'd1);
`endif
        chk("s1_we_idle", imem_we, 32'd0);
        chk("s1_busy_off", busy, 32'd0);

        // Session 2: back-to-back DPR, LDR, STR(last).
        pulse_start();
        chk("s2_wc_cleared", word_count, 32'd0);
        chk("s2_done_off", done, 32'd0);
        drive(3'd1, 4'hE, 2'b01, 1'b1, 4'd4, 4'd3, 4'd5, 24'h000000, 1'b0);
        tick();
        chk("dpr_wd", imem_wd, 32'hE0543005);
        chk("dpr_addr", imem_addr, 32'd0);
        drive(3'd2, 4'hE, 2'b00, 1'b1, 4'd7, 4'd6, 4'd0, 24'h000008, 1'b0);
        tick();
        chk("ldr_we", imem_we, 32'd1);
        chk("ldr_wd", imem_wd, 32'hE5976008);
        chk("ldr_addr", imem_addr, 32'd1);
        drive(3'd3, 4'hE, 2'b00, 1'b1, 4'd7, 4'd6, 4'd0, 24'h000008, 1'b1);
        tick();
        idle_req();
        chk("str_we", imem_we, 32'd1);
        chk("str_wd", imem_wd, 32'hE5876008);
        chk("str_addr", imem_addr, 32'd2);
        tick();
`ifdef ENCODER_HALT_PAD_EN
        chk("s2_pad_wd", imem_wd, 32'hEAFFFFFE);
        chk("s2_pad_addr", imem_addr, 32'd3);
        tick();
        chk("s2_wc", word_count, 32'd4);
`else
        chk("s2_wc", word_count, 32'd3);
`endif
        chk("s2_done", done, 32'd1);
        chk("s2_full", full, 32'd0);

        // Session 3: ORR DPR, illegal kind (with an ignored start), then B(last).
        pulse_start();
        drive(3'd1, 4'h0, 2'b11, 1'b0, 4'd1, 4'd0, 4'd2, 24'h000000, 1'b0);
        tick();
        chk("orr_wd", imem_wd, 32'h01810002);
        chk("orr_addr", imem_addr, 32'd0);
        drive(3'd7, 4'hE, 2'b00, 1'b0, 4'd1, 4'd1, 4'd1, 24'h000001, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_we", imem_we, 32'd0);
        chk("ill_err", err_illegal, 32'd1);
        chk("ill_wc_kept", word_count, 32'd1);
        chk("ill_busy", busy, 32'd1);
        drive(3'd4, 4'hE, 2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 24'h000003, 1'b1);
        tick();
        idle_req();
        chk("b_we", imem_we, 32'd1);
        chk("b_wd", imem_wd, 32'hEA000003);
        chk("b_addr", imem_addr, 32'd1);
        tick();
`ifdef ENCODER_HALT_PAD_EN
        chk("s3_pad_addr", imem_addr, 32'd2);
        tick();
        chk("s3_wc", word_count, 32'd3);
`else
        chk("s3_wc", word_count, 32'd2);
`endif
        chk("s3_done", done, 32'd1);
        chk("s3_err_sticky", err_illegal, 32'd1);

        // Session 4: reset colliding with an accept, then reset during a write.
        pulse_start();
        drive(3'd0, 4'hE, 2'b00, 1'b0, 4'd2, 4'd1, 4'd0, 24'h000005, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_req();
        chk_all_zero("rst_accept");
        pulse_start();
        drive(3'd0, 4'hE, 2'b00, 1'b0, 4'd2, 4'd1, 4'd0, 24'h000005, 1'b0);
        tick();
        idle_req();
        chk("pre_rst_we", imem_we, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("rst_write");
        pulse_start();
        drive(3'd4, 4'hE, 2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 24'h000003, 1'b1);
        tick();
        idle_req();
        chk("restart_addr", imem_addr, 32'd0);
        chk("restart_wd", imem_wd, 32'hEA000003);
        tick();
        tick();
        tick();

        // ADDR_W=2 instance: five requests without req_last fill four words.
        reset2 = 1'b0;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'd0, 4'hE, 2'b00, 1'b0, 4'd0, 4'(i), 4'd0, 24'(i), 1'b0);
            tick();
            chk("lim_we", imem_we2, 32'd1);
            chk("lim_addr", imem_addr2, 32'(i));
            chk("lim_wd", imem_wd2, 32'hE2800000 | (32'(i) << 12) | 32'(i));
        end
        drive(3'd0, 4'hE, 2'b00, 1'b0, 4'd0, 4'd4, 4'd0, 24'h000004, 1'b0);
        chk("lim_ready_last", req_ready2, 32'd0);
        tick();
        chk("lim_no_5th_we", imem_we2, 32'd0);
        chk("lim_full", full2, 32'd1);
        chk("lim_done", done2, 32'd1);
        chk("lim_ready", req_ready2, 32'd0);
        chk("lim_wc", word_count2, 32'd4);
        tick();
        chk("lim_still_no_we", imem_we2, 32'd0);
        chk("lim_wc_hold", word_count2, 32'd4);
        idle_req();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encodes instruction fields into 32-bit ARM machine words for the subset the processor control unit decodes: DP-immediate, DP-register, LDR, STR and B.
- Writes the encoded words sequentially into instruction memory through a write port.
- Sits between a host/test loader and imem; it boots programs into the single-cycle processor before release from halt.
- The encoding is the exact inverse of the processor's Op/Funct/Rd field decode.

Parameters:
- ADDR_W, 6, word-address width of imem; depth = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session.
- req_valid  in  1  instruction request valid.
- req_ready  out  1  encoder can accept a request this cycle.
- req_last  in  1  marks the final instruction of the program.
- req_kind  in  3  0=DPI, 1=DPR, 2=LDR, 3=STR, 4=B; 5..7 illegal.
- req_cond  in  4  condition field, bits [31:28].
- req_alu  in  2  DP op: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- req_s  in  1  S bit (DP only).
- req_rn, req_rd, req_rm  in  4 each  register numbers.
- req_imm  in  24  DPI uses [11:0] as {rot,imm8}; LDR/STR use [11:0] as imm12; B uses [23:0].
- imem_we  out  1  imem write strobe.
- imem_addr  out  ADDR_W  imem word address.
- imem_wd  out  32  encoded word.
- word_count  out  ADDR_W+1  words written this session.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- full  out  1  session ended because the last imem address was written.
- err_illegal  out  1  sticky; an illegal req_kind was accepted this session.

Behaviour:
- Reset: state=IDLE; all outputs 0; pointer=BASE_ADDR.
- FSM states: IDLE, LOAD, DONE.
  - IDLE or DONE + start -> LOAD. Pointer=BASE_ADDR; word_count, full and err_illegal cleared.
  - start while in LOAD is ignored.
- req_ready = (state==LOAD) & ~last_seen & ~full. A transfer occurs when req_valid & req_ready.
- Latency: a request accepted in cycle N produces a registered imem_we=1 in cycle N+1, with imem_addr=pointer and imem_wd=encoded word.
  - Pointer and word_count increment at the end of cycle N+1.
  - Back-to-back requests are accepted, one per cycle.
  - imem_we is 0 in every other cycle.
- Encoding. Common field: [31:28]=cond. cmd map: ADD=0100, SUB=0010, AND=0000, ORR=1100.
  - DPI: [27:26]=00, [25]=1, [24:21]=cmd, [20]=S, [19:16]=Rn, [15:12]=Rd, [11:0]=req_imm[11:0].
  - DPR: as DPI with [25]=0 and [11:0]={8'b0, Rm}.
  - LDR/STR: [27:26]=01, [25:20]=01100L with L=1 for LDR and L=0 for STR, Rn/Rd as DP, [11:0]=imm12. req_s is ignored.
  - B: [27:24]=1010, [23:0]=req_imm.
- Illegal kind: the request is consumed, no write occurs, the pointer is unchanged and err_illegal is set.
  - If req_last is set on an illegal request, the session still ends.
- Session end: the state goes LOAD->DONE in the cycle after the write of the req_last word, or after the write to address 2**ADDR_W-1.
  - In the address-limit case full=1; further requests are not accepted (req_ready=0).
  - The pointer never wraps.
- reset mid-session aborts immediately: no imem_we is issued for a pending word.

Optional Feature:
- ENCODER_HALT_PAD_EN defined: after the req_last word, one extra write of 0xEAFFFFFE (B to self, cond AL) is issued at the next address in the following cycle; it is counted in word_count.
  - If the req_last word occupied the last address, the pad is dropped and full=1.
- Macro undefined: no pad word is written.

Test Plan:
- start, then DPI cond=E alu=ADD S=0 Rn=2 Rd=1 imm=0x005 -> next cycle imem_we=1, addr=0, wd=0xE2821005.
- Back-to-back DPR SUB S=1 Rn=4 Rd=3 Rm=5, then LDR Rn=7 Rd=6 imm=8, then STR (same fields, req_last) -> writes 0xE0543005@0, 0xE5976008@1, 0xE5876008@2 on consecutive cycles; done=1, word_count=3. With the macro defined, 0xEAFFFFFE is also written @3 and word_count=4.
- DPR cond=0 ORR Rn=1 Rd=0 Rm=2 -> 0x01810002. B cond=E imm=0x000003 -> 0xEA000003.
- req_kind=7 mid-stream -> no imem_we, err_illegal=1, the next legal word lands at the unchanged address.
- ADDR_W=2: 5 requests without req_last -> 4 writes (addr 0..3), then full=1, done=1, req_ready=0, and the 5th request is not accepted.
- reset asserted in the cycle after an accept -> imem_we stays 0 and all outputs read 0 the next cycle. A subsequent start restarts at BASE_ADDR.
